arbiter: RTL and testbench
==========================

// Module: arbiter
//
// PURPOSE
// - Two-requester round-robin arbiter with a registered, one-hot (or zero) grant.
// - Samples request[1:0] every clk edge and drives grant[1:0] one cycle later.
// - Guarantees mutual exclusion and alternates fairly when both requesters contend.
// - Sits between two bus masters and a shared resource; grant drives the resource-select mux.
//
// PARAMETERS
// - None. Requester count is fixed at 2.
//
// PORTS
// - clk      input   1  single clock; all state updates on posedge clk
// - reset    input   1  synchronous, active-high reset, sampled on posedge clk
// - request  input   2  request[i]=1: requester i wants the resource this cycle
// - grant    output  2  registered grant; grant[i]=1: requester i owns the resource
//
// BEHAVIOUR
// - Timing
//   - Single clock, clk.
//   - reset is synchronous and active-high: it acts only at posedge clk while high.
//   - grant is a flop output. Combinational next-grant from (request, last_served) is
//     registered on posedge clk: 1-cycle latency from request sampled to grant visible.
// - State
//   - grant_q[1:0]: the grant register.
//   - last_served (1 bit): index of the requester most recently granted.
// - Reset (posedge clk with reset=1)
//   - grant_q <= 2'b00 and last_served <= 1'b1, so requester 0 wins the first contention.
//   - grant reads 2'b00 at every edge following an edge where reset was high.
//   - Reset mid-operation drops any active grant to 00 on that edge, regardless of request.
// - Next-grant rules (reset=0), evaluated on sampled request
//   - 2'b00 -> grant 2'b00; idle, no parking.
//   - 2'b01 -> grant 2'b01; last_served <= 0.
//   - 2'b10 -> grant 2'b10; last_served <= 1.
//   - 2'b11 -> grant the requester != last_served, then update last_served.
//     - Result: continuous 11 yields 01,10,01,10... strictly alternating every cycle.
//     - Previous grant 01 with request 11 -> next grant 10 (and the reverse).
//   - If request is 00, last_served holds its value.
// - Invariants (checked with reset low)
//   - Never grant == 2'b11.
//   - request[i]==0 at edge N -> grant[i]==0 after edge N+1.
//   - No request is dropped while its requester's request stays high: a requester
//     held high waits at most 1 cycle.
// - No handshake, no hold/lock: a grant lasts only as long as the request is re-sampled high.
// - Outputs are never X after the first reset edge.
//
// STRUCTURE
// - Package arbiter_pkg
//   - localparam GNT_NONE=2'b00, GNT_0=2'b01, GNT_1=2'b10.
//   - typedef logic [1:0] req_t.
// - Single module, no sub-modules.
//   - One always_comb for next-grant and next-last_served.
//   - One always_ff for the registers with the synchronous reset branch.
// - Optional internal SVA block under `ifdef ARB_SVA
//   - Properties: mutex, single-request grant, fairness, no-spurious-grant, reset.
//
// TESTING
// - Reset: reset=1 for 9 cycles with any request
//   -> grant==00 every cycle; after release with request=00 -> grant stays 00.
// - Single requester: request=01 for 6 cycles -> grant==01 from the 2nd edge on.
//   Mirror with request=10 -> grant==10.
// - Alternating: request toggles 01/10 every 2 cycles for 20 cycles
//   -> grant follows with 1-cycle lag; never grants the idle side.
// - Contention: request=11 for 20 cycles after a grant of 01
//   -> grant 10,01,10,...; never 11, never two equal grants in a row.
// - Random: 500 cycles of random request, assertions enabled
//   -> zero violations of mutex, single-request, fairness and spurious-grant properties.
// - Reset mid-operation: reset=1 during request=11 with grant=10
//   -> next grant 00; after release, first 11 contention grants 01.

Source files
------------

// File: rtl/arbiter_pkg.sv
// ----------------------------------------------------------------------------
// arbiter_pkg
// Shared types and constants for the two-requester round-robin arbiter.
//   GNT_NONE / GNT_0 / GNT_1 : the only legal grant encodings (zero or one-hot)
//   req_t                    : two-bit request vector, bit i = requester i
//   rr_pick()                : contention winner given the last served index
// ----------------------------------------------------------------------------
package arbiter_pkg;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

    typedef logic [1:0] req_t;

    // When both requesters contend, the one that was not served last wins.
    function automatic logic [1:0] rr_pick(input logic last_served);
        logic [1:0] pick;
        if (last_served == 1'b1) begin
            pick = GNT_0;
        end else begin
            pick = GNT_1;
        end
        return pick;
    endfunction

endpackage : arbiter_pkg

// File: rtl/arbiter.sv
// ----------------------------------------------------------------------------
// arbiter
// Two-requester round-robin arbiter with a registered grant. The request
// vector sampled on a rising edge determines the grant visible after that
// edge. Grants are always zero or one-hot; under continuous contention the
// grant alternates every cycle.
//
// Ports
//   clk      in   1  clock, all state changes on posedge
//   reset    in   1  synchronous active-high reset
//   request  in   2  request[i]=1: requester i wants the resource
//   grant    out  2  registered grant, grant[i]=1: requester i owns it
// ----------------------------------------------------------------------------
module arbiter
    import arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  req_t       request,
    output logic [1:0] grant
);

    logic [1:0] grant_q;
    logic [1:0] grant_d;
    logic       last_q;   // index of the requester granted most recently
    logic       last_d;

    // Next grant and next last-served index from the sampled request.
    always_comb begin
        grant_d = GNT_NONE;
        last_d  = last_q;
        case (request)
            2'b00: begin
                // Idle: no parking, history kept for the next contention.
                grant_d = GNT_NONE;
                last_d  = last_q;
            end
            2'b01: begin
                grant_d = GNT_0;
                last_d  = 1'b0;
            end
            2'b10: begin
                grant_d = GNT_1;
                last_d  = 1'b1;
            end
            2'b11: begin
                grant_d = rr_pick(last_q);
                last_d  = ~last_q;
            end
            default: begin
                // Unknown request bits: grant nothing, keep history.
                grant_d = GNT_NONE;
                last_d  = last_q;
            end
        endcase
    end

    // Grant and history registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= GNT_NONE;
            last_q  <= 1'b1;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign grant = grant_q;

endmodule : arbiter

// File: tb/tb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_arbiter
// Directed bench for the round-robin arbiter followed by a random phase.
// ----------------------------------------------------------------------------
module tb_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] request;
    logic [1:0] grant;

    int vectors;
    int miscompares;

    arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .request (request),
        .grant   (grant)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, let the edge pass, then compare grant.
    task automatic step(input logic r, input logic [1:0] q, input logic [1:0] e, input string tag);
        reset   = r;
        request = q;
        @(posedge clk);
        #1;
        check(tag, grant, e);
    endtask

    initial begin
        logic [1:0] q;
        logic [1:0] exp;
        logic [1:0] prev_q;
        logic       last;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        request     = 2'b00;

        // Reset held for 9 cycles with assorted requests: grant stays 00.
        for (int i = 0; i < 9; i++) begin
            q = 2'(i % 4);
            step(1'b1, q, 2'b00, "reset_hold");
        end

        // Released and idle: grant stays 00.
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 2'b00, "idle_after_reset");

        // Single requester 0, then single requester 1.
        for (int i = 0; i < 6; i++) step(1'b0, 2'b01, 2'b01, "single_req0");
        for (int i = 0; i < 6; i++) step(1'b0, 2'b10, 2'b10, "single_req1");
        step(1'b0, 2'b00, 2'b00, "idle_gap");

        // Alternating 01/10 every 2 cycles: grant tracks with one-cycle lag.
        for (int i = 0; i < 20; i++) begin
            q = ((i / 2) % 2 == 0) ? 2'b01 : 2'b10;
            step(1'b0, q, q, "alternating");
        end

        // Grant 01 first, then continuous contention: 10,01,10,...
        step(1'b0, 2'b01, 2'b01, "pre_contention");
        for (int i = 0; i < 20; i++) begin
            exp = (i % 2 == 0) ? 2'b10 : 2'b01;
            step(1'b0, 2'b11, exp, "contention");
        end
        // Contention ended on 01, so the next 11 grants 10.
        step(1'b0, 2'b11, 2'b10, "contention_to_10");

        // Reset during 11 with grant 10 drops the grant; first contention after goes to 0.
        step(1'b1, 2'b11, 2'b00, "mid_reset");
        step(1'b0, 2'b11, 2'b01, "post_reset_first");
        step(1'b0, 2'b11, 2'b10, "post_reset_second");

        // Random phase: last served is requester 1 here.
        last   = 1'b1;
        prev_q = 2'b11;
        for (int i = 0; i < 500; i++) begin
            q = 2'($urandom_range(3, 0));
            case (q)
                2'b01:   begin exp = 2'b01; last = 1'b0; end
                2'b10:   begin exp = 2'b10; last = 1'b1; end
                2'b11:   begin exp = last ? 2'b01 : 2'b10; last = ~last; end
                default: begin exp = 2'b00; end
            endcase
            step(1'b0, q, exp, "random");
            // Independent invariants: mutex and no grant to a silent requester.
            vectors++;
            assert ((grant !== 2'b11) && ((grant & ~q) === 2'b00)) else begin
                miscompares++;
                $error("FAIL rand_invariant: observed %b request %b prev %b", grant, q, prev_q);
            end
            prev_q = q;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_arbiter
